// File: rtl/clause_merge_tree.sv
`default_nettype none
// ============================================================================
//  Module      : clause_merge_tree
//  Description : Collects batches of clauses into LANES leaf FIFOs and funnels
//                them through a binary tree of round-robin merge nodes to one
//                valid/ready output stream. Provides input backpressure,
//                synchronous flush, a sticky error flag and an occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module clause_merge_tree #(
    parameter int CLAUSE_COUNT = 20,
    parameter int CLAUSE_WIDTH = 36,
    parameter int LANES        = 4,
    parameter int BUFFER_DEPTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] clauses_i,
    input  logic [CLAUSE_COUNT-1:0]              clauses_valid_i,
    input  logic                                 wr_valid_i,
    output logic                                 wr_ready_o,
    output logic [CLAUSE_WIDTH-1:0]              clause_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    input  logic                                 flush_i,
    input  logic                                 cOF_i,
    output logic                                 OF_o,
    output logic [15:0]                          count_o
);

    // Clauses per leaf, tree size, pointer widths.
    localparam int c_GROUP = CLAUSE_COUNT / LANES;
    localparam int c_INNER = LANES - 1;
    localparam int c_NODES = 2 * LANES - 1;
    localparam int c_AW    = $clog2(BUFFER_DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam int c_KW    = (c_GROUP > 1) ? $clog2(c_GROUP) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DIST = 1'b1
    } state_t;

    // Nodes are stored heap-style: node 0 is the root, children of node n are
    // 2n+1 and 2n+2, and leaf i lives at node c_INNER+i.
    logic [CLAUSE_WIDTH-1:0] r_mem    [c_NODES][BUFFER_DEPTH];
    logic [c_AW-1:0]         r_rd_ptr [c_NODES];
    logic [c_AW-1:0]         r_wr_ptr [c_NODES];
    logic [c_CW-1:0]         r_cnt    [c_NODES];
    logic [c_INNER-1:0]      r_prio;

    logic [c_NODES-1:0]      w_push;
    logic [c_NODES-1:0]      w_pop;
    logic [c_NODES-1:0]      w_full;
    logic [c_NODES-1:0]      w_nempty;
    logic [c_INNER-1:0]      w_src;
    logic [CLAUSE_WIDTH-1:0] w_head   [c_NODES];
    logic [CLAUSE_WIDTH-1:0] w_wdata  [c_NODES];

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_KW-1:0]         r_k;
    logic [CLAUSE_WIDTH-1:0] r_batch  [LANES][c_GROUP];
    logic [c_GROUP-1:0]      r_mask   [LANES];

    logic [CLAUSE_WIDTH-1:0] w_in_clause [LANES][c_GROUP];
    logic [c_GROUP-1:0]      w_in_mask   [LANES];
    logic [LANES-1:0]        w_leaf_we;
    logic [CLAUSE_WIDTH-1:0] w_leaf_data [LANES];

    logic                    w_room;
    logic                    w_accept;
    logic                    w_wr_overflow;
    logic [15:0]             w_nwr;
    logic                    r_of;
    logic [15:0]             r_count;

    // Slice the flat batch into per-leaf, per-offset clauses.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            for (genvar gj = 0; gj < c_GROUP; gj++) begin : g_slot
                assign w_in_clause[gi][gj] =
                    clauses_i[(gi*c_GROUP+gj)*CLAUSE_WIDTH +: CLAUSE_WIDTH];
                assign w_in_mask[gi][gj] = clauses_valid_i[gi*c_GROUP+gj];
            end
        end
    endgenerate

    // Per-node status flags and first-word fall-through heads.
    generate
        for (genvar gn = 0; gn < c_NODES; gn++) begin : g_status
            assign w_head[gn]   = r_mem[gn][r_rd_ptr[gn]];
            assign w_full[gn]   = (r_cnt[gn] == c_CW'(BUFFER_DEPTH));
            assign w_nempty[gn] = (r_cnt[gn] != '0);
        end
    endgenerate

    // A batch may only be accepted when every leaf can take a whole group.
    always_comb begin
        w_room = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (r_cnt[c_INNER+i] > c_CW'(BUFFER_DEPTH - c_GROUP)) begin
                w_room = 1'b0;
            end
        end
    end

    assign wr_ready_o = (r_state == S_IDLE) && w_room;
    assign w_accept   = wr_valid_i && wr_ready_o && !flush_i;

    // Distributor next-state: one DIST cycle per remaining offset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (c_GROUP > 1)) begin
                    w_state_nxt = S_DIST;
                end
            end
            S_DIST: begin
                if (r_k == c_KW'(c_GROUP - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Leaf writes: offset 0 straight from the inputs in the accept cycle,
    // later offsets from the registered batch.
    always_comb begin
        w_nwr = '0;
        for (int i = 0; i < LANES; i++) begin
            w_leaf_we[i]   = 1'b0;
            w_leaf_data[i] = w_in_clause[i][0];
            if (r_state == S_IDLE) begin
                w_leaf_we[i] = w_accept && w_in_mask[i][0];
            end else begin
                w_leaf_we[i]   = r_mask[i][r_k];
                w_leaf_data[i] = r_batch[i][r_k];
            end
            if (flush_i) begin
                w_leaf_we[i] = 1'b0;
            end
            w_nwr = w_nwr + 16'(w_leaf_we[i]);
        end
    end

    // Merge arbitration, resolved root-first so each node knows whether its
    // parent frees a slot this cycle.
    always_comb begin
        w_push = '0;
        w_pop  = '0;
        w_src  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_push[c_INNER+i] = w_leaf_we[i];
        end
        w_pop[0] = w_nempty[0] && out_ready_i;
        for (int n = 0; n < c_INNER; n++) begin
            if ((!w_full[n] || w_pop[n]) &&
                (w_nempty[2*n+1] || w_nempty[2*n+2])) begin
                w_push[n] = 1'b1;
                w_src[n]  = r_prio[n] ? w_nempty[2*n+2] : !w_nempty[2*n+1];
                if (w_src[n]) begin
                    w_pop[2*n+2] = 1'b1;
                end else begin
                    w_pop[2*n+1] = 1'b1;
                end
            end
        end
        if (flush_i) begin
            w_push = '0;
            w_pop  = '0;
        end
    end

    // Write data per node: leaves from the distributor, inner nodes from the
    // selected child head.
    always_comb begin
        for (int n = 0; n < c_NODES; n++) begin
            w_wdata[n] = '0;
        end
        for (int n = 0; n < c_INNER; n++) begin
            w_wdata[n] = w_src[n] ? w_head[2*n+2] : w_head[2*n+1];
        end
        for (int i = 0; i < LANES; i++) begin
            w_wdata[c_INNER+i] = w_leaf_data[i];
        end
    end

    assign w_wr_overflow = |(w_push & w_full & ~w_pop);

    // Distributor state and offset counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_i) begin
                r_k <= '0;
            end else if (r_state == S_IDLE) begin
                r_k <= c_KW'(1);
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    // Capture the batch at accept; inputs are free to change afterwards.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                r_mask[i] <= w_in_mask[i];
                for (int j = 0; j < c_GROUP; j++) begin
                    r_batch[i][j] <= w_in_clause[i][j];
                end
            end
        end
    end

    // FIFO pointers and occupancy for every node.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int n = 0; n < c_NODES; n++) begin
                r_rd_ptr[n] <= '0;
                r_wr_ptr[n] <= '0;
                r_cnt[n]    <= '0;
            end
        end else begin
            for (int n = 0; n < c_NODES; n++) begin
                if (w_push[n] && (!w_full[n] || w_pop[n])) begin
                    r_wr_ptr[n] <= r_wr_ptr[n] + 1'b1;
                end
                if (w_pop[n]) begin
                    r_rd_ptr[n] <= r_rd_ptr[n] + 1'b1;
                end
                if (w_push[n] && !w_pop[n] && !w_full[n]) begin
                    r_cnt[n] <= r_cnt[n] + 1'b1;
                end else if (!w_push[n] && w_pop[n]) begin
                    r_cnt[n] <= r_cnt[n] - 1'b1;
                end
            end
        end
    end

    // FIFO storage; a write into a full, non-popping FIFO is dropped.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < c_NODES; n++) begin
            if (w_push[n] && (!w_full[n] || w_pop[n])) begin
                r_mem[n][r_wr_ptr[n]] <= w_wdata[n];
            end
        end
    end

    // Round-robin pointers: after serving a child, prefer the other one.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_prio <= '0;
        end else begin
            for (int n = 0; n < c_INNER; n++) begin
                if (w_push[n]) begin
                    r_prio[n] <= !w_src[n];
                end
            end
        end
    end

    // Occupancy: leaf writes in, root pops out.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + w_nwr - 16'(w_pop[0]);
        end
    end

    // Sticky error flag; clear wins over a same-cycle set.
    always_ff @(posedge clk_i) begin
        if (rst_i || cOF_i) begin
            r_of <= 1'b0;
        end else if (w_wr_overflow || (wr_valid_i && !wr_ready_o)) begin
            r_of <= 1'b1;
        end
    end

    assign out_valid_o = w_nempty[0];
    assign clause_o    = w_nempty[0] ? w_head[0] : '0;
    assign OF_o        = r_of;
    assign count_o     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_clause_merge_tree.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clause_merge_tree
//  Description : Directed self-checking bench for clause_merge_tree, covering
//                the default 4-lane tree and an 8-lane / 16-clause variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clause_merge_tree;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [719:0]  clauses;
    logic [19:0]   mask;
    logic          wr_valid, wr_ready, out_valid, out_ready, flush, cof, of;
    logic [35:0]   clause_q;
    logic [15:0]   count;

    logic [575:0]  clauses8;
    logic [15:0]   mask8;
    logic          wr_valid8, wr_ready8, out_valid8, out_ready8, flush8, cof8, of8;
    logic [35:0]   clause8;
    logic [15:0]   count8;

    clause_merge_tree u_dut (
        .clk_i(clk), .rst_i(rst), .clauses_i(clauses), .clauses_valid_i(mask),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .clause_o(clause_q),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .flush_i(flush),
        .cOF_i(cof), .OF_o(of), .count_o(count)
    );

    clause_merge_tree #(.CLAUSE_COUNT(16), .CLAUSE_WIDTH(36), .LANES(8), .BUFFER_DEPTH(32)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .clauses_i(clauses8), .clauses_valid_i(mask8),
        .wr_valid_i(wr_valid8), .wr_ready_o(wr_ready8), .clause_o(clause8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8), .flush_i(flush8),
        .cOF_i(cof8), .OF_o(of8), .count_o(count8)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int peak4    = 0;
    int accepted = 0;
    logic [35:0] q4[$];
    logic [35:0] q8[$];

    // Output monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) q4.push_back(clause_q);
        if (out_valid8 && out_ready8) q8.push_back(clause8);
        if (int'(count) > peak4) peak4 = int'(count);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream must hold exactly n_exp distinct values base..base+n_exp-1,
    // strictly ascending within each leaf.
    task automatic check_stream(input string tag, input logic [35:0] q[$], input int n_exp,
                                input int base, input int modv, input int g);
        int last[16];
        for (int i = 0; i < 16; i++) last[i] = -1;
        check({tag, "_count"}, 64'(q.size()), 64'(n_exp));
        foreach (q[j]) begin
            int v;
            int leaf;
            logic ok;
            v  = int'(q[j][31:0]) - base;
            ok = (v >= 0) && (v < n_exp);
            if (ok) begin
                leaf = (v % modv) / g;
                ok   = v > last[leaf];
                last[leaf] = v;
            end
            check({tag, "_order"}, 64'(ok), 64'(1));
        end
    endtask

    task automatic load4(input int base);
        for (int k = 0; k < 20; k++) clauses[k*36 +: 36] = 36'(base + k);
    endtask

    initial begin
        rst = 1'b1; clauses = '0; mask = '0; wr_valid = 1'b0; out_ready = 1'b0;
        flush = 1'b0; cof = 1'b0;
        clauses8 = '0; mask8 = '0; wr_valid8 = 1'b0; out_ready8 = 1'b0;
        flush8 = 1'b0; cof8 = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_wr_ready", 64'(wr_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_clause", 64'(clause_q), 64'(0));
        check("rst_of", 64'(of), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst8_out_valid", 64'(out_valid8), 64'(0));
        rst = 1'b0;
        tick();

        // Full batch, clause k = k, consumer always ready
        out_ready = 1'b1; load4(0); mask = '1; q4.delete();
        wr_valid = 1'b1;
        tick(); wr_valid = 1'b0;                              // T+1
        check("full_ready_t1", 64'(wr_ready), 64'(0));
        check("full_count_t1", 64'(count), 64'(4));
        check("full_valid_t1", 64'(out_valid), 64'(0));
        tick();                                               // T+2
        check("full_ready_t2", 64'(wr_ready), 64'(0));
        check("full_valid_t2", 64'(out_valid), 64'(0));
        tick();                                               // T+3
        check("full_valid_t3", 64'(out_valid), 64'(1));
        check("full_clause_t3", 64'(clause_q), 64'(0));
        tick();                                               // T+4
        check("full_ready_t4", 64'(wr_ready), 64'(0));
        check("full_clause_t4", 64'(clause_q), 64'(10));
        tick();                                               // T+5
        check("full_ready_t5", 64'(wr_ready), 64'(1));
        for (int i = 0; i < 60 && (count != 0 || out_valid); i++) tick();
        check("full_count_end", 64'(count), 64'(0));
        check("full_of", 64'(of), 64'(0));
        check_stream("full", q4, 20, 0, 20, 5);

        // Sparse mask: only clauses 0 and 19
        out_ready = 1'b0; load4(32'h100); mask = 20'h80001; q4.delete(); peak4 = 0;
        wr_valid = 1'b1;
        tick(); wr_valid = 1'b0;
        repeat (8) tick();
        check("sparse_count", 64'(count), 64'(2));
        check("sparse_peak", 64'(peak4), 64'(2));
        out_ready = 1'b1;
        repeat (10) tick();
        check("sparse_n", 64'(q4.size()), 64'(2));
        if (q4.size() == 2) begin
            check("sparse_first", 64'(q4[0]), 64'h100);
            check("sparse_second", 64'(q4[1]), 64'h113);
        end
        check("sparse_count_end", 64'(count), 64'(0));

        // Backpressure: consumer stalled, batches offered whenever accepted
        out_ready = 1'b0; mask = '1; q4.delete(); accepted = 0;
        for (int c = 0; c < 400; c++) begin
            if (wr_ready) begin
                load4(accepted * 20);
                wr_valid = 1'b1;
                accepted++;
            end else begin
                wr_valid = 1'b0;
            end
            tick();
        end
        wr_valid = 1'b0;
        tick();
        check("bp_ready_low", 64'(wr_ready), 64'(0));
        check("bp_ge6_batches", 64'(accepted >= 6), 64'(1));
        check("bp_count", 64'(count), 64'(accepted * 20));
        check("bp_of_clear", 64'(of), 64'(0));

        // Offer while not ready: ignored, flags error, then cleared
        load4(32'h7000); wr_valid = 1'b1;
        tick(); wr_valid = 1'b0;
        check("ovf_of_set", 64'(of), 64'(1));
        check("ovf_count", 64'(count), 64'(accepted * 20));
        cof = 1'b1;
        tick(); cof = 1'b0;
        check("ovf_of_cleared", 64'(of), 64'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 400 && (count != 0 || out_valid); i++) tick();
        check("bp_drain_count", 64'(count), 64'(0));
        check_stream("bp", q4, accepted * 20, 0, 20, 5);

        // Flush in the middle of a batch
        out_ready = 1'b0; load4(32'h300); mask = '1; q4.delete();
        wr_valid = 1'b1;
        tick(); wr_valid = 1'b0;                              // T+1
        tick();                                               // T+2
        check("flush_pre_count", 64'(count), 64'(8));
        flush = 1'b1;
        tick(); flush = 1'b0;                                 // T+3
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_count", 64'(count), 64'(0));
        check("flush_ready", 64'(wr_ready), 64'(1));
        out_ready = 1'b1;
        repeat (15) tick();
        check("flush_no_stale", 64'(q4.size()), 64'(0));
        check("flush_count_end", 64'(count), 64'(0));
        check("flush_of", 64'(of), 64'(0));

        // 8-lane tree, 16 clauses
        out_ready8 = 1'b1; mask8 = '1; q8.delete();
        for (int k = 0; k < 16; k++) clauses8[k*36 +: 36] = 36'(32'h200 + k);
        wr_valid8 = 1'b1;
        tick(); wr_valid8 = 1'b0;                             // T+1
        check("l8_ready_t1", 64'(wr_ready8), 64'(0));
        tick();                                               // T+2
        check("l8_ready_t2", 64'(wr_ready8), 64'(1));
        tick();                                               // T+3
        check("l8_valid_t3", 64'(out_valid8), 64'(0));
        tick();                                               // T+4
        check("l8_valid_t4", 64'(out_valid8), 64'(1));
        check("l8_clause_t4", 64'(clause8), 64'h200);
        for (int i = 0; i < 60 && (count8 != 0 || out_valid8); i++) tick();
        check("l8_count_end", 64'(count8), 64'(0));
        check_stream("l8", q8, 16, 32'h200, 16, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
